// File: rtl/tdm_demux_1to4.sv
// Receive side of the 4:1 TDM link: realigns on slot-0 frame sync, assembles
// slot words in shadow registers and publishes each complete frame at once.
module tdm_demux_1to4 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [4*WIDTH-1:0]   dout,
    output logic                 frame_done,
    output logic [3:0]           lane_strobe,
    output logic [1:0]           slot,
    output logic                 sync_err,
    output logic                 locked
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              slot_q, slot_d;
    logic [2:0][WIDTH-1:0]   shadow_q, shadow_d;
    logic [4*WIDTH-1:0]      dout_q, dout_d;
    logic                    frame_done_q, frame_done_d;
    logic [3:0]              lane_strobe_q, lane_strobe_d;
    logic                    sync_err_q, sync_err_d;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        shadow_d      = shadow_q;
        dout_d        = dout_q;
        frame_done_d  = 1'b0;
        lane_strobe_d = 4'b0000;
        sync_err_d    = 1'b0;

        if (din_valid) begin
            if (frame_sync && (state_q == IDLE || slot_q == 2'd0 || state_q == RUN)) begin
                // Any sync beat starts a fresh frame; off-slot-0 in RUN is an early sync.
                sync_err_d    = (state_q == RUN) && (slot_q != 2'd0);
                shadow_d[0]   = din;
                lane_strobe_d = 4'b0001;
                slot_d        = 2'd1;
                state_d       = RUN;
            end else if (state_q == RUN) begin
                if (slot_q == 2'd0) begin
                    sync_err_d = 1'b1;
                    slot_d     = 2'd0;
                    state_d    = IDLE;
                end else begin
                    lane_strobe_d[slot_q] = 1'b1;
                    slot_d                = slot_q + 2'd1;
                    case (slot_q)
                        2'd1:    shadow_d[1] = din;
                        2'd2:    shadow_d[2] = din;
                        default: begin
                            // Last slot bypasses its shadow and goes straight to dout.
                            dout_d       = {din, shadow_q[2], shadow_q[1], shadow_q[0]};
                            frame_done_d = 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            slot_q        <= 2'd0;
            shadow_q      <= '0;
            dout_q        <= '0;
            frame_done_q  <= 1'b0;
            lane_strobe_q <= 4'b0000;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            shadow_q      <= shadow_d;
            dout_q        <= dout_d;
            frame_done_q  <= frame_done_d;
            lane_strobe_q <= lane_strobe_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign dout        = dout_q;
    assign frame_done  = frame_done_q;
    assign lane_strobe = lane_strobe_q;
    assign slot        = slot_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Bench for tdm_demux_1to4: scenario tasks with inline checks plus a frame
// scoreboard that pops the expected dout on every frame_done.
module tb_tdm_demux_1to4;

    localparam int WIDTH = 8;

    logic                 clk;
    logic                 rst_n;
    logic [WIDTH-1:0]     din;
    logic                 din_valid;
    logic                 frame_sync;
    logic [4*WIDTH-1:0]   dout;
    logic                 frame_done;
    logic [3:0]           lane_strobe;
    logic [1:0]           slot;
    logic                 sync_err;
    logic                 locked;

    int errors = 0;
    int checks = 0;
    logic [4*WIDTH-1:0] exp_q[$];

    tdm_demux_1to4 #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .dout        (dout),
        .frame_done  (frame_done),
        .lane_strobe (lane_strobe),
        .slot        (slot),
        .sync_err    (sync_err),
        .locked      (locked)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every frame_done must match the oldest expected frame.
    always @(posedge clk) begin
        #1;
        if (frame_done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_frame_done: got dout=%h, want no frame_done", dout);
            end else begin
                logic [4*WIDTH-1:0] exp_v;
                exp_v = exp_q.pop_front();
                if (dout !== exp_v) begin
                    errors++;
                    $display("FAIL sb_dout: got %h want %h", dout, exp_v);
                end
            end
        end
    end

    // Driver tasks
    task automatic drive_beat(input logic [WIDTH-1:0] d, input logic s);
        @(negedge clk);
        din        = d;
        frame_sync = s;
        din_valid  = 1'b1;
        @(posedge clk);
        #1;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Scenarios
    task automatic test_reset();
        din = '0; din_valid = 1'b0; frame_sync = 1'b0; rst_n = 1'b0;
        idle_cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({dout, frame_done, lane_strobe, slot, sync_err, locked} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got dout=%h fd=%b ls=%b slot=%0d err=%b lock=%b want all 0",
                     dout, frame_done, lane_strobe, slot, sync_err, locked);
        end
    endtask

    task automatic test_clean_frame();
        logic [WIDTH-1:0] data [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) begin
            logic [3:0] exp_lane;
            logic [1:0] exp_slot;
            exp_lane = 4'b0001 << i;
            exp_slot = 2'(i + 1);
            if (i == 3) exp_q.push_back(32'hD4C3B2A1);
            drive_beat(data[i], i == 0);
            checks++;
            if (lane_strobe !== exp_lane || slot !== exp_slot || sync_err !== 1'b0 || locked !== 1'b1
                || frame_done !== (i == 3)) begin
                errors++;
                $display("FAIL clean_beat%0d: got ls=%b slot=%0d err=%b lock=%b fd=%b want ls=%b slot=%0d err=0 lock=1 fd=%b",
                         i, lane_strobe, slot, sync_err, locked, frame_done, exp_lane, exp_slot, i == 3);
            end
        end
        idle_cycles(1);
        checks++;
        if (frame_done !== 1'b0 || dout !== 32'hD4C3B2A1 || lane_strobe !== 4'b0000) begin
            errors++;
            $display("FAIL clean_after: got fd=%b dout=%h ls=%b want fd=0 dout=d4c3b2a1 ls=0000",
                     frame_done, dout, lane_strobe);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            logic [1:0] exp_slot;
            exp_slot = 2'(i + 1);
            if (i == 3) exp_q.push_back(32'h44332211);
            drive_beat(data[i], i == 0);
            checks++;
            if (slot !== exp_slot || lane_strobe !== (4'b0001 << i)) begin
                errors++;
                $display("FAIL b2b_beat%0d: got slot=%0d ls=%b want slot=%0d ls=%b",
                         i, slot, lane_strobe, exp_slot, 4'b0001 << i);
            end
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    idle_cycles(1);
                    checks++;
                    if (dout !== 32'hD4C3B2A1 || lane_strobe !== 4'b0000 || slot !== exp_slot) begin
                        errors++;
                        $display("FAIL b2b_gap%0d_%0d: got dout=%h ls=%b slot=%0d want dout=d4c3b2a1 ls=0000 slot=%0d",
                                 i, g, dout, lane_strobe, slot, exp_slot);
                    end
                end
            end
        end
        checks++;
        if (dout !== 32'h44332211 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_publish: got dout=%h fd=%b want 44332211 fd=1", dout, frame_done);
        end
    endtask

    task automatic test_pre_lock_garbage();
        logic [WIDTH-1:0] junk [2] = '{8'hFF, 8'hEE};
        logic [WIDTH-1:0] data [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            drive_beat(junk[i], 1'b0);
            checks++;
            if (lane_strobe !== 4'b0000 || sync_err !== 1'b0 || locked !== 1'b0 || slot !== 2'd0) begin
                errors++;
                $display("FAIL prelock_junk%0d: got ls=%b err=%b lock=%b slot=%0d want 0000 0 0 0",
                         i, lane_strobe, sync_err, locked, slot);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_q.push_back(32'h04030201);
            drive_beat(data[i], i == 0);
        end
        checks++;
        if (dout !== 32'h04030201 || locked !== 1'b1) begin
            errors++;
            $display("FAIL prelock_frame: got dout=%h lock=%b want 04030201 lock=1", dout, locked);
        end
    endtask

    task automatic test_early_sync();
        drive_beat(8'h10, 1'b1);
        drive_beat(8'h20, 1'b0);
        checks++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("FAIL early_pre_err: got %b want 0", sync_err);
        end
        drive_beat(8'h30, 1'b1);
        checks++;
        if (sync_err !== 1'b1 || lane_strobe !== 4'b0001 || slot !== 2'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL early_sync_beat: got err=%b ls=%b slot=%0d lock=%b want 1 0001 1 1",
                     sync_err, lane_strobe, slot, locked);
        end
        drive_beat(8'h40, 1'b0);
        checks++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("FAIL early_err_pulse: got %b want 0", sync_err);
        end
        drive_beat(8'h50, 1'b0);
        exp_q.push_back(32'h60504030);
        drive_beat(8'h60, 1'b0);
        checks++;
        if (dout !== 32'h60504030 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL early_publish: got dout=%h fd=%b want 60504030 fd=1", dout, frame_done);
        end
    endtask

    task automatic test_missing_sync();
        drive_beat(8'h77, 1'b0);
        checks++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || slot !== 2'd0 || lane_strobe !== 4'b0000) begin
            errors++;
            $display("FAIL missing_sync: got err=%b lock=%b slot=%0d ls=%b want 1 0 0 0000",
                     sync_err, locked, slot, lane_strobe);
        end
        drive_beat(8'h78, 1'b0);
        checks++;
        if (sync_err !== 1'b0 || locked !== 1'b0 || dout !== 32'h60504030) begin
            errors++;
            $display("FAIL missing_after: got err=%b lock=%b dout=%h want 0 0 60504030", sync_err, locked, dout);
        end
    endtask

    task automatic test_async_reset();
        drive_beat(8'h5A, 1'b1);
        drive_beat(8'h6B, 1'b0);
        drive_beat(8'h7C, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== '0 || locked !== 1'b0 || slot !== 2'd0 || lane_strobe !== 4'b0000
            || frame_done !== 1'b0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got dout=%h lock=%b slot=%0d ls=%b fd=%b err=%b want all 0",
                     dout, locked, slot, lane_strobe, frame_done, sync_err);
        end
        idle_cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        // A lone slot-3 word after reset must not complete the lost frame.
        drive_beat(8'h8D, 1'b0);
        idle_cycles(3);
        checks++;
        if (dout !== '0 || locked !== 1'b0 || lane_strobe !== 4'b0000) begin
            errors++;
            $display("FAIL async_after: got dout=%h lock=%b ls=%b want 0 0 0000", dout, locked, lane_strobe);
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_back_to_back();
        test_pre_lock_garbage();
        test_early_sync();
        test_missing_sync();
        test_async_reset();
        idle_cycles(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d frames pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
